// File: rtl/instr_fetch_unit.sv
// Instruction fetch and branch sequencer feeding the micro-instruction ROM.
// Optional return stack for BSR/RET is built when INSTR_FETCH_STACK_EN is defined.
module instr_fetch_unit #(
    parameter int IW        = 16,
    parameter int AW        = 10,
    parameter int STK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic          mem_ready,
    input  logic [IW-1:0] mem_data,
    output logic [5:0]    opcode,
    output logic [IW-7:0] operand,
    output logic          instr_valid,
    input  logic          exec_done,
    input  logic [3:0]    flags,
    output logic [AW-1:0] pc,
    output logic          stk_err
);

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_ISSUE  = 2'd2;

    localparam logic [5:0] OP_JZE = 6'b000000;
    localparam logic [5:0] OP_JNE = 6'b000001;
    localparam logic [5:0] OP_JOV = 6'b000010;
    localparam logic [5:0] OP_JCY = 6'b000011;
    localparam logic [5:0] OP_JMP = 6'b000100;
    localparam logic [5:0] OP_BSR = 6'b001100;
    localparam logic [5:0] OP_RET = 6'b001101;

    logic [1:0]    state;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] target;
    logic [AW-1:0] br_pc;
    logic          is_branch;
    logic          do_push;
    logic          do_pop;
    logic          set_err;

    assign pc_inc   = pc + AW'(1);
    assign target   = operand[AW-1:0];
    assign mem_addr = pc;

`ifdef INSTR_FETCH_STACK_EN
    localparam int SPW = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

    logic [AW-1:0]  stk_mem [STK_DEPTH];
    logic [SPW:0]   sp;
    logic [SPW-1:0] top_idx;
    logic           stk_full;
    logic           stk_empty;
    logic           err_q;

    assign top_idx   = SPW'(sp - 1'b1);
    assign stk_full  = (sp == (SPW+1)'(STK_DEPTH));
    assign stk_empty = (sp == '0);
    assign stk_err   = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sp    <= '0;
            err_q <= 1'b0;
        end else if (state == ST_DECODE) begin
            if (set_err) err_q <= 1'b1;
            if (do_push) sp <= sp + 1'b1;
            else if (do_pop) sp <= sp - 1'b1;
        end
    end

    // Storage needs no reset; sp alone defines what is valid.
    always_ff @(posedge clk) begin
        if (!reset && state == ST_DECODE && do_push)
            stk_mem[sp[SPW-1:0]] <= pc_inc;
    end
`else
    assign stk_err = 1'b0;
`endif

    always_comb begin
        is_branch = 1'b1;
        br_pc     = pc_inc;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        set_err   = 1'b0;
        case (opcode)
            OP_JMP: br_pc = target;
            OP_JZE: if (flags[3]) br_pc = target;
            OP_JNE: if (flags[2]) br_pc = target;
            OP_JOV: if (flags[1]) br_pc = target;
            OP_JCY: if (flags[0]) br_pc = target;
            OP_BSR: begin
                br_pc = target;
`ifdef INSTR_FETCH_STACK_EN
                if (stk_full) set_err = 1'b1;
                else          do_push = 1'b1;
`endif
            end
            OP_RET: begin
`ifdef INSTR_FETCH_STACK_EN
                if (stk_empty) begin
                    set_err = 1'b1;
                end else begin
                    do_pop = 1'b1;
                    br_pc  = stk_mem[top_idx];
                end
`endif
            end
            default: is_branch = 1'b0;
        endcase
    end

    // mem_rd is registered: after reset one idle FETCH cycle passes before the request rises.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_FETCH;
            pc          <= '0;
            mem_rd      <= 1'b0;
            opcode      <= 6'b111111;
            operand     <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (!mem_rd) begin
                        mem_rd <= 1'b1;
                    end else if (mem_ready) begin
                        opcode  <= mem_data[IW-1:IW-6];
                        operand <= mem_data[IW-7:0];
                        mem_rd  <= 1'b0;
                        state   <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (is_branch) begin
                        pc     <= br_pc;
                        mem_rd <= 1'b1;
                        state  <= ST_FETCH;
                    end else begin
                        instr_valid <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (exec_done) begin
                        instr_valid <= 1'b0;
                        pc          <= pc_inc;
                        mem_rd      <= 1'b1;
                        state       <= ST_FETCH;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule
